// File: rtl/i2c_target_regs.sv
// I2C target exposing four 8-bit configuration registers at a 7-bit address.
// SCL/SDA are oversampled on clk, glitch-filtered, and SDA is driven open-drain.
module i2c_target_regs #(
  parameter logic [6:0]  DEV_ADDR   = 7'h1A,
  parameter int          FILTER_LEN = 4,
  parameter logic [31:0] REG_INIT   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        scl_in,
  input  logic        sda_in,
  output logic        sda_oe,
  output logic [31:0] reg_out,
  output logic        wr_strobe,
  output logic [1:0]  wr_index,
  output logic        busy
);

  localparam logic [3:0] CNT_LAST = 4'(FILTER_LEN - 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_ADDR,
    S_ADDR_ACK,
    S_PTR,
    S_PTR_ACK,
    S_WDATA,
    S_WDATA_ACK,
    S_RDATA,
    S_RACK_WAIT,
    S_IGNORE
  } state_t;

  // Line index 0 = SCL, 1 = SDA.
  logic [1:0]      w_pin;
  logic [1:0]      r_meta;
  logic [1:0]      r_sync;
  logic [1:0]      r_filt;
  logic [1:0][3:0] r_cnt;
  logic [1:0]      r_rise;
  logic [1:0]      r_fall;

  assign w_pin = {sda_in, scl_in};

  // Synchronizers and filters reset to the idle-bus level so that releasing
  // reset on a quiet bus produces no edge flags.
  // NOTE: clocked state is written only with non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_meta <= '1;
      r_sync <= '1;
      r_filt <= '1;
      r_cnt  <= '0;
      r_rise <= '0;
      r_fall <= '0;
    end else begin
      r_meta <= w_pin;
      r_sync <= r_meta;
      r_rise <= '0;
      r_fall <= '0;
      for (int i = 0; i < 2; i++) begin
        if (r_sync[i] == r_filt[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == CNT_LAST) begin
          r_filt[i] <= r_sync[i];
          r_cnt[i]  <= '0;
          r_rise[i] <= r_sync[i];
          r_fall[i] <= ~r_sync[i];
        end else begin
          r_cnt[i] <= r_cnt[i] + 4'd1;
        end
      end
    end
  end

  logic w_scl;
  logic w_sda;
  logic w_scl_rise;
  logic w_scl_fall;
  logic w_start;
  logic w_stop;

  assign w_scl      = r_filt[0];
  assign w_sda      = r_filt[1];
  assign w_scl_rise = r_rise[0];
  assign w_scl_fall = r_fall[0];
  assign w_start    = r_fall[1] & w_scl;
  assign w_stop     = r_rise[1] & w_scl;

  state_t      r_state;
  logic [2:0]  r_bit_cnt;
  logic [7:0]  r_shift;
  logic        r_rw;
  logic        r_ack_on;
  logic        r_rd_pend;
  logic [1:0]  r_ptr;
  logic [31:0] r_regs;
  logic        r_sda_oe;
  logic        r_busy;
  logic        r_wr_strobe;
  logic [1:0]  r_wr_index;

  state_t      w_state_nxt;
  logic [2:0]  w_bit_cnt_nxt;
  logic [7:0]  w_shift_nxt;
  logic        w_rw_nxt;
  logic        w_ack_on_nxt;
  logic        w_rd_pend_nxt;
  logic [1:0]  w_ptr_nxt;
  logic [31:0] w_regs_nxt;
  logic        w_sda_oe_nxt;
  logic        w_busy_nxt;
  logic        w_wr_strobe_nxt;
  logic [1:0]  w_wr_index_nxt;

  logic [7:0]  w_byte;
  logic [7:0]  w_sel_reg;

  assign w_byte    = {r_shift[6:0], w_sda};
  assign w_sel_reg = r_regs[{r_ptr, 3'b000} +: 8];

  // NOTE: every signal gets its hold value first, so paths that do not assign
  // it cannot infer a latch.
  always_comb begin
    w_state_nxt     = r_state;
    w_bit_cnt_nxt   = r_bit_cnt;
    w_shift_nxt     = r_shift;
    w_rw_nxt        = r_rw;
    w_ack_on_nxt    = r_ack_on;
    w_rd_pend_nxt   = r_rd_pend;
    w_ptr_nxt       = r_ptr;
    w_regs_nxt      = r_regs;
    w_sda_oe_nxt    = r_sda_oe;
    w_busy_nxt      = r_busy;
    w_wr_strobe_nxt = 1'b0;
    w_wr_index_nxt  = r_wr_index;

    if (w_stop) begin
      w_state_nxt   = S_IDLE;
      w_sda_oe_nxt  = 1'b0;
      w_busy_nxt    = 1'b0;
      w_ack_on_nxt  = 1'b0;
      w_rd_pend_nxt = 1'b0;
    end else if (w_start) begin
      w_state_nxt   = S_ADDR;
      w_bit_cnt_nxt = '0;
      w_sda_oe_nxt  = 1'b0;
      w_busy_nxt    = 1'b0;
      w_ack_on_nxt  = 1'b0;
      w_rd_pend_nxt = 1'b0;
    end else begin
      unique case (r_state)
        S_ADDR: begin
          if (w_scl_rise) begin
            w_shift_nxt   = w_byte;
            w_bit_cnt_nxt = r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) begin
              if (w_byte[7:1] == DEV_ADDR) begin
                w_state_nxt = S_ADDR_ACK;
                w_busy_nxt  = 1'b1;
                w_rw_nxt    = w_byte[0];
              end else begin
                w_state_nxt = S_IGNORE;
              end
            end
          end
        end

        // First SCL fall starts driving the ACK, the second one ends it.
        S_ADDR_ACK: begin
          if (w_scl_fall) begin
            if (!r_ack_on) begin
              w_sda_oe_nxt = 1'b1;
              w_ack_on_nxt = 1'b1;
            end else begin
              w_ack_on_nxt = 1'b0;
              if (r_rw) begin
                w_state_nxt  = S_RDATA;
                w_shift_nxt  = w_sel_reg;
                w_sda_oe_nxt = ~w_sel_reg[7];
              end else begin
                w_state_nxt  = S_PTR;
                w_sda_oe_nxt = 1'b0;
              end
            end
          end
        end

        S_PTR: begin
          if (w_scl_rise) begin
            w_shift_nxt   = w_byte;
            w_bit_cnt_nxt = r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) begin
              w_ptr_nxt   = w_byte[1:0];
              w_state_nxt = S_PTR_ACK;
            end
          end
        end

        S_PTR_ACK, S_WDATA_ACK: begin
          if (w_scl_fall) begin
            if (!r_ack_on) begin
              w_sda_oe_nxt = 1'b1;
              w_ack_on_nxt = 1'b1;
            end else begin
              w_sda_oe_nxt = 1'b0;
              w_ack_on_nxt = 1'b0;
              w_state_nxt  = S_WDATA;
            end
          end
        end

        S_WDATA: begin
          if (w_scl_rise) begin
            w_shift_nxt   = w_byte;
            w_bit_cnt_nxt = r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) begin
              w_regs_nxt[{r_ptr, 3'b000} +: 8] = w_byte;
              w_wr_strobe_nxt = 1'b1;
              w_wr_index_nxt  = r_ptr;
              w_ptr_nxt       = r_ptr + 2'd1;
              w_state_nxt     = S_WDATA_ACK;
            end
          end
        end

        // The bit counter wraps to 0 after the 8th rise, which marks the
        // fall that hands the ninth clock to the master.
        S_RDATA: begin
          if (w_scl_rise) begin
            w_shift_nxt   = {r_shift[6:0], 1'b0};
            w_bit_cnt_nxt = r_bit_cnt + 3'd1;
          end else if (w_scl_fall) begin
            if (r_rd_pend) begin
              w_sda_oe_nxt  = ~r_shift[7];
              w_rd_pend_nxt = 1'b0;
            end else if (r_bit_cnt == 3'd0) begin
              w_sda_oe_nxt = 1'b0;
              w_ptr_nxt    = r_ptr + 2'd1;
              w_state_nxt  = S_RACK_WAIT;
            end else begin
              w_sda_oe_nxt = ~r_shift[7];
            end
          end
        end

        S_RACK_WAIT: begin
          if (w_scl_rise) begin
            if (!w_sda) begin
              w_shift_nxt   = w_sel_reg;
              w_rd_pend_nxt = 1'b1;
              w_state_nxt   = S_RDATA;
            end else begin
              w_state_nxt = S_IGNORE;
              w_busy_nxt  = 1'b0;
            end
          end
        end

        default: ;
      endcase
    end
  end

  // NOTE: the register file is reset explicitly because its contents are
  // configuration that must be defined (REG_INIT) from the first cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_rw        <= 1'b0;
      r_ack_on    <= 1'b0;
      r_rd_pend   <= 1'b0;
      r_ptr       <= '0;
      r_regs      <= REG_INIT;
      r_sda_oe    <= 1'b0;
      r_busy      <= 1'b0;
      r_wr_strobe <= 1'b0;
      r_wr_index  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_bit_cnt   <= w_bit_cnt_nxt;
      r_shift     <= w_shift_nxt;
      r_rw        <= w_rw_nxt;
      r_ack_on    <= w_ack_on_nxt;
      r_rd_pend   <= w_rd_pend_nxt;
      r_ptr       <= w_ptr_nxt;
      r_regs      <= w_regs_nxt;
      r_sda_oe    <= w_sda_oe_nxt;
      r_busy      <= w_busy_nxt;
      r_wr_strobe <= w_wr_strobe_nxt;
      r_wr_index  <= w_wr_index_nxt;
    end
  end

  assign sda_oe    = r_sda_oe;
  assign reg_out   = r_regs;
  assign wr_strobe = r_wr_strobe;
  assign wr_index  = r_wr_index;
  assign busy      = r_busy;

endmodule

// File: tb/tb_i2c_target_regs.sv
// Directed bench for i2c_target_regs: a bit-banged I2C master on a wired-AND
// SDA line, with hand-computed expected register and read-back values.
module tb_i2c_target_regs;

  localparam int Q = 10;  // clk cycles per quarter SCL period

  logic        clk     = 1'b0;
  logic        reset_n = 1'b0;
  logic        m_scl   = 1'b1;
  logic        m_sda   = 1'b1;
  logic        scl_in;
  logic        sda_in;
  logic        sda_oe;
  logic [31:0] reg_out;
  logic        wr_strobe;
  logic [1:0]  wr_index;
  logic        busy;

  i2c_target_regs #(
    .DEV_ADDR  (7'h1A),
    .FILTER_LEN(4),
    .REG_INIT  (32'h4433_2211)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .scl_in   (scl_in),
    .sda_in   (sda_in),
    .sda_oe   (sda_oe),
    .reg_out  (reg_out),
    .wr_strobe(wr_strobe),
    .wr_index (wr_index),
    .busy     (busy)
  );

  assign scl_in = m_scl;
  assign sda_in = m_sda & ~sda_oe;

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_errors = 0;
  int         strobe_n = 0;
  int         oe_n     = 0;
  logic [1:0] strobe_idx [16];

  always @(negedge clk) begin
    if (wr_strobe) begin
      if (strobe_n < 16) strobe_idx[strobe_n] = wr_index;
      strobe_n = strobe_n + 1;
    end
    if (sda_oe) oe_n = oe_n + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (got !== exp) begin
      n_errors = n_errors + 1;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic write_bit(input logic b, input bit glitch);
    m_sda = b;
    if (glitch) begin
      tick(Q / 2);
      m_scl = 1'b1;
      tick(1);
      m_scl = 1'b0;
      tick(Q - Q / 2 - 1);
    end else begin
      tick(Q);
    end
    m_scl = 1'b1;
    tick(2 * Q);
    m_scl = 1'b0;
    tick(Q);
  endtask

  task automatic read_bit(output logic b);
    m_sda = 1'b1;
    tick(Q);
    m_scl = 1'b1;
    tick(Q);
    b = sda_in;
    tick(Q);
    m_scl = 1'b0;
    tick(Q);
  endtask

  task automatic write_byte(input logic [7:0] d, input int glitch_bit, output logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) write_bit(d[i], i == glitch_bit);
    read_bit(b);
    ack = ~b;
  endtask

  task automatic read_byte(input logic send_ack, output logic [7:0] d);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      d[i] = b;
    end
    write_bit(~send_ack, 1'b0);
  endtask

  task automatic bus_start;
    m_sda = 1'b1;
    tick(Q);
    m_scl = 1'b1;
    tick(Q);
    m_sda = 1'b0;
    tick(Q);
    m_scl = 1'b0;
    tick(Q);
  endtask

  task automatic bus_stop;
    m_sda = 1'b0;
    tick(Q);
    m_scl = 1'b1;
    tick(Q);
    m_sda = 1'b1;
    tick(Q);
  endtask

  initial begin
    logic       ack;
    logic [7:0] d;
    int         s0;
    int         o0;

    // Reset values
    tick(3);
    check("rst_reg_out", reg_out, 32'h4433_2211);
    check("rst_sda_oe", 32'(sda_oe), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_wr_strobe", 32'(wr_strobe), 32'd0);
    check("rst_wr_index", 32'(wr_index), 32'd0);
    reset_n = 1'b1;
    tick(2 * Q);

    // Write burst with pointer wrap 3 -> 0
    s0 = strobe_n;
    bus_start();
    write_byte(8'h34, -1, ack);
    check("wb_addr_ack", 32'(ack), 32'd1);
    check("wb_busy", 32'(busy), 32'd1);
    write_byte(8'h02, -1, ack);
    check("wb_ptr_ack", 32'(ack), 32'd1);
    write_byte(8'hAA, -1, ack);
    check("wb_d0_ack", 32'(ack), 32'd1);
    write_byte(8'hBB, -1, ack);
    check("wb_d1_ack", 32'(ack), 32'd1);
    write_byte(8'hCC, -1, ack);
    check("wb_d2_ack", 32'(ack), 32'd1);
    bus_stop();
    tick(Q);
    check("wb_reg_out", reg_out, 32'hBBAA_22CC);
    check("wb_strobe_cnt", 32'(strobe_n - s0), 32'd3);
    check("wb_idx0", 32'(strobe_idx[0]), 32'd2);
    check("wb_idx1", 32'(strobe_idx[1]), 32'd3);
    check("wb_idx2", 32'(strobe_idx[2]), 32'd0);
    check("wb_busy_stop", 32'(busy), 32'd0);

    // Pointer set, repeated START, two-byte read ending in NACK
    bus_start();
    write_byte(8'h34, -1, ack);
    check("rd_waddr_ack", 32'(ack), 32'd1);
    write_byte(8'h01, -1, ack);
    check("rd_ptr_ack", 32'(ack), 32'd1);
    bus_start();
    write_byte(8'h35, -1, ack);
    check("rd_raddr_ack", 32'(ack), 32'd1);
    read_byte(1'b1, d);
    check("rd_byte0", 32'(d), 32'h22);
    check("rd_busy_mid", 32'(busy), 32'd1);
    read_byte(1'b0, d);
    check("rd_byte1", 32'(d), 32'hAA);
    check("rd_busy_nack", 32'(busy), 32'd0);
    check("rd_oe_nack", 32'(sda_oe), 32'd0);
    bus_stop();

    // Wrong address: target stays silent
    s0 = strobe_n;
    o0 = oe_n;
    bus_start();
    write_byte(8'h36, -1, ack);
    check("wa_addr_nack", 32'(ack), 32'd0);
    write_byte(8'h00, -1, ack);
    check("wa_ptr_nack", 32'(ack), 32'd0);
    write_byte(8'hFF, -1, ack);
    check("wa_data_nack", 32'(ack), 32'd0);
    bus_stop();
    tick(Q);
    check("wa_oe_cycles", 32'(oe_n - o0), 32'd0);
    check("wa_strobes", 32'(strobe_n - s0), 32'd0);
    check("wa_reg_out", reg_out, 32'hBBAA_22CC);

    // 2-clk SDA dip with SCL high must not be a START
    o0 = oe_n;
    tick(Q);
    m_sda = 1'b0;
    tick(2);
    m_sda = 1'b1;
    tick(2 * Q);
    check("gl_busy", 32'(busy), 32'd0);
    m_scl = 1'b0;
    tick(Q);
    write_byte(8'h34, -1, ack);
    check("gl_no_start_ack", 32'(ack), 32'd0);
    check("gl_oe_cycles", 32'(oe_n - o0), 32'd0);
    bus_stop();

    // 1-clk SCL pulse inside a data bit must not shift a bit
    s0 = strobe_n;
    bus_start();
    write_byte(8'h34, 3, ack);
    check("gl_scl_addr_ack", 32'(ack), 32'd1);
    write_byte(8'h00, -1, ack);
    check("gl_scl_ptr_ack", 32'(ack), 32'd1);
    write_byte(8'h5A, -1, ack);
    check("gl_scl_data_ack", 32'(ack), 32'd1);
    bus_stop();
    tick(Q);
    check("gl_scl_reg_out", reg_out, 32'hBBAA_225A);
    check("gl_scl_strobes", 32'(strobe_n - s0), 32'd1);
    if (strobe_n - 1 < 16) check("gl_scl_idx", 32'(strobe_idx[strobe_n - 1]), 32'd0);

    // Reset while the target drives SDA during a read
    bus_start();
    write_byte(8'h35, -1, ack);
    check("mr_addr_ack", 32'(ack), 32'd1);
    check("mr_oe_driving", 32'(sda_oe), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("mr_oe_async", 32'(sda_oe), 32'd0);
    check("mr_busy", 32'(busy), 32'd0);
    check("mr_reg_out", reg_out, 32'h4433_2211);
    m_scl = 1'b1;
    m_sda = 1'b1;
    tick(Q);
    reset_n = 1'b1;
    tick(2 * Q);
    bus_start();
    write_byte(8'h35, -1, ack);
    check("mr_readdr_ack", 32'(ack), 32'd1);
    read_byte(1'b0, d);
    check("mr_read_reg0", 32'(d), 32'h11);
    bus_stop();
    tick(Q);
    check("mr_busy_end", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
